// File: rtl/deserializador_pcie_pkg.sv
// Shared definitions for the PCIe-style lane deserializer: comma value,
// FSM state encoding and the comma compare helper.
package deserializador_pcie_pkg;

  localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic is_com(input logic [7:0] i_byte, input logic [7:0] i_com);
    return (i_byte == i_com);
  endfunction

endpackage

// File: rtl/comma_detector.sv
// Serial-in shift register with a look-ahead comma compare. o_sr_n is the
// window the register will hold after the current bit is taken, so the FSM
// can act on a completed byte on the same edge that samples its last bit.
module comma_detector
  import deserializador_pcie_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_data,
  output logic [7:0] o_sr_n,
  output logic       o_match
);

  logic [7:0] r_sr;
  logic [7:0] w_sr_n;

  assign w_sr_n  = {r_sr[6:0], i_data};
  assign o_sr_n  = w_sr_n;
  assign o_match = is_com(w_sr_n, COM_SYMBOL);

  // Shift in one bit per qualified clock; hold when the lane is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= 8'h00;
    end else if (i_valid) begin
      r_sr <= w_sr_n;
    end
  end

endmodule

// File: rtl/deserializador_pcie.sv
// Serial-to-parallel lane receiver: aligns on the comma symbol, then emits
// one byte with a single-cycle strobe every 8 qualified bits.
//
// state  | meaning
// SEARCH | sliding bit-by-bit comma hunt, no byte alignment yet
// CHECK  | comma seen, confirming further byte-spaced commas
// LOCKED | aligned; every 8th qualified bit produces a byte strobe
module deserializador_pcie
  import deserializador_pcie_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int         LOCK_COUNT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       k_out,
  output logic       sync
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] r_com_cnt;
  logic [3:0] w_com_cnt_nxt;
  logic       w_emit;
  logic [7:0] w_sr_n;
  logic       w_match;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_k;

  comma_detector #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_comma_detector (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_valid (valid_in),
    .i_data  (data_in),
    .o_sr_n  (w_sr_n),
    .o_match (w_match)
  );

  // State and counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= SEARCH;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
    end
  end

  // Next-state, counter update and byte-emit decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_com_cnt_nxt = r_com_cnt;
    w_emit        = 1'b0;
    case (r_state)
      SEARCH: begin
        if (valid_in && w_match) begin
          w_com_cnt_nxt = 4'd1;
          w_bit_cnt_nxt = 3'd0;
          if (LOCK_COUNT == 1) begin
            w_state_nxt = LOCKED;
            w_emit      = 1'b1;
          end else begin
            w_state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        if (!valid_in) begin
          w_state_nxt   = SEARCH;
          w_bit_cnt_nxt = 3'd0;
          w_com_cnt_nxt = 4'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (w_match) begin
              if ((r_com_cnt + 4'd1) == LC) begin
                w_state_nxt = LOCKED;
                w_emit      = 1'b1;
              end else begin
                w_com_cnt_nxt = r_com_cnt + 4'd1;
              end
            end else begin
              // Misaligned byte: resume the sliding hunt from the next bit.
              w_state_nxt   = SEARCH;
              w_com_cnt_nxt = 4'd0;
            end
          end
        end
      end
      LOCKED: begin
        if (!valid_in) begin
          w_state_nxt   = SEARCH;
          w_bit_cnt_nxt = 3'd0;
          w_com_cnt_nxt = 4'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_emit = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = SEARCH;
        w_bit_cnt_nxt = 3'd0;
        w_com_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Output registers: strobe lasts one cycle, byte and K flag hold between strobes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_data <= w_sr_n;
        r_k    <= w_match;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign k_out     = r_k;
  assign sync      = (r_state == LOCKED);

endmodule

// File: tb/tb_deserializador_pcie.sv
// Bench for the lane deserializer: two instances (lock after 1 and after 2
// commas) share one serial stream; a bit-level reference model predicts each
// strobe and its cycle, and a negedge monitor scores the DUT outputs.
module tb_deserializador_pcie;

  localparam logic [7:0] COM = 8'hBC;

  logic        clk;
  logic        reset_n;
  logic        data_in;
  logic        valid_in;
  logic [15:0] dout;
  logic [1:0]  vout;
  logic [1:0]  kout;
  logic [1:0]  syn;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [7:0] d;
    logic       k;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // reference model state
  int         lc[2] = '{1, 2};
  bit         lk[2];
  int         coms[2];
  int         pos[2];
  logic [7:0] win;
  logic [7:0] last_d[2];
  logic       last_k[2];

  deserializador_pcie #(.COM_SYMBOL(COM), .LOCK_COUNT(1)) dut1 (
    .CLK(clk), .RESET(reset_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(dout[7:0]), .valid_out(vout[0]), .k_out(kout[0]), .sync(syn[0])
  );

  deserializador_pcie #(.COM_SYMBOL(COM), .LOCK_COUNT(2)) dut2 (
    .CLK(clk), .RESET(reset_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(dout[15:8]), .valid_out(vout[1]), .k_out(kout[1]), .sync(syn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  function automatic void model_reset();
    win = 8'h00;
    for (int i = 0; i < 2; i++) begin
      lk[i] = 1'b0; coms[i] = 0; pos[i] = 0;
    end
  endfunction

  function automatic void push(input int i, input logic [7:0] d, input logic k);
    exp_t e;
    e.d = d; e.k = k; e.cyc = cyc + 1;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Effect of the next clock edge on the link, given the bit about to be presented.
  function automatic void model_step(input logic b, input logic v);
    if (v) win = {win[6:0], b};
    for (int i = 0; i < 2; i++) begin
      if (!v) begin
        lk[i] = 1'b0; coms[i] = 0; pos[i] = 0;
      end else if (lk[i]) begin
        pos[i]++;
        if (pos[i] == 8) begin
          pos[i] = 0;
          push(i, win, win == COM);
        end
      end else if (coms[i] == 0) begin
        if (win == COM) begin
          coms[i] = 1; pos[i] = 0;
          if (lc[i] == 1) begin lk[i] = 1'b1; push(i, COM, 1'b1); end
        end
      end else begin
        pos[i]++;
        if (pos[i] == 8) begin
          pos[i] = 0;
          if (win == COM) begin
            coms[i]++;
            if (coms[i] == lc[i]) begin lk[i] = 1'b1; push(i, COM, 1'b1); end
          end else begin
            coms[i] = 0;
          end
        end
      end
    end
  endfunction

  task automatic send_bit(input logic b, input logic v);
    @(negedge clk);
    #2;
    data_in  = b;
    valid_in = v;
    model_step(b, v);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) send_bit(b[j], 1'b1);
  endtask

  task automatic mon(input int i);
    logic       v, k, s;
    logic [7:0] d;
    exp_t       e;
    int         n;
    v = vout[i]; k = kout[i]; s = syn[i];
    d = (i == 0) ? dout[7:0] : dout[15:8];
    n = (i == 0) ? q0.size() : q1.size();
    if (!reset_n) begin last_d[i] = 8'h00; last_k[i] = 1'b0; end
    if (n > 0) e = (i == 0) ? q0[0] : q1[0];
    if (v) begin
      compared++;
      if (n == 0 || e.cyc != cyc) begin
        mismatched++;
        $display("FAIL strobe_unexpected inst%0d cyc=%0d got data=%h k=%b want no strobe", i, cyc, d, k);
      end else begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        last_d[i] = e.d; last_k[i] = e.k;
      end
    end else if (n > 0 && e.cyc == cyc) begin
      compared++;
      mismatched++;
      $display("FAIL strobe_missing inst%0d cyc=%0d got none want data=%h", i, cyc, e.d);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      last_d[i] = e.d; last_k[i] = e.k;
    end
    chk($sformatf("data_out_inst%0d", i), d, last_d[i]);
    chk($sformatf("k_out_inst%0d", i), {7'd0, k}, {7'd0, last_k[i]});
    chk($sformatf("sync_inst%0d", i), {7'd0, s}, {7'd0, lk[i]});
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  initial begin
    logic [7:0] stream1[9] = '{8'h25, 8'hBC, 8'hF9, 8'h4F, 8'hA6, 8'h39, 8'hA8, 8'hF9, 8'h4F};
    logic [7:0] rb;
    logic [7:0] part;
    reset_n  = 1'b1;
    data_in  = 1'b0;
    valid_in = 1'b0;
    last_d[0] = 8'h00; last_d[1] = 8'h00;
    last_k[0] = 1'b0;  last_k[1] = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;

    // alignment and full locked stream
    foreach (stream1[i]) send_byte(stream1[i]);

    // two-comma lock: aligned COM followed by a non-COM byte, then a clean pair
    send_bit(1'b0, 1'b0);
    send_byte(8'hBC); send_byte(8'hF9); send_byte(8'hBC); send_byte(8'hA6);
    send_bit(1'b0, 1'b0);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hF9);

    // loss of lock mid-byte, then relock
    part = 8'h5A;
    for (int j = 7; j >= 5; j--) send_bit(part[j], 1'b1);
    send_bit(1'b0, 1'b0);
    send_byte(8'hBC); send_byte(8'hA6);

    // async reset right after a strobe, with the next byte partly presented
    send_bit(1'b0, 1'b0);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hF9);
    send_bit(1'b1, 1'b1);
    #1;
    reset_n  = 1'b0;
    valid_in = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_valid_inst%0d", i), {7'd0, vout[i]}, 8'h00);
      chk($sformatf("async_sync_inst%0d", i), {7'd0, syn[i]}, 8'h00);
      chk($sformatf("async_k_inst%0d", i), {7'd0, kout[i]}, 8'h00);
    end
    chk("async_data_inst0", dout[7:0], 8'h00);
    chk("async_data_inst1", dout[15:8], 8'h00);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    send_byte(8'hA6); send_byte(8'h39); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hF9);

    // streams that never contain the comma
    send_bit(1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      send_byte(8'h00); send_byte(8'hFF);
    end

    // randomized traffic with frequent commas and sporadic idle bits
    for (int n = 0; n < 150; n++) begin
      rb = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom);
      for (int j = 7; j >= 0; j--) send_bit(rb[j], $urandom_range(0, 63) != 0);
    end

    send_bit(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("pending_strobes_inst0", 8'(q0.size()), 8'h00);
    chk("pending_strobes_inst1", 8'(q1.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/deserializador_pcie.md
Name: deserializador_pcie

Overview:
- Receive end of the parallel-to-serial-to-parallel PCIe-style link: takes the 1-bit serial stream produced by the serializer and rebuilds bytes.
- Byte alignment comes from the COM symbol 8'hBC (K28.5 stand-in).
- Once locked, emits one byte plus a one-cycle valid every 8 valid bits, flags COM bytes, and reports link sync.
- Sits between the serial lane and the parallel-side logic/probe.

Parameters:
COM_SYMBOL, 8'hBC, alignment/comma byte value
LOCK_COUNT, 1, number of consecutive byte-spaced COMs needed to declare lock (range 1..15)

Ports:
CLK  input  1  bit clock, rising-edge
RESET  input  1  asynchronous, active-low reset (0 = reset)
data_in  input  1  serial bit, MSB of each byte first
valid_in  input  1  data_in qualifier; bit sampled only when 1
data_out  output  8  recovered byte
valid_out  output  1  one-cycle strobe, data_out/k_out valid
k_out  output  1  data_out equals COM_SYMBOL
sync  output  1  high while in LOCKED

Behaviour:
- RESET=0, async: shift reg, bit_cnt, com_cnt cleared; state=SEARCH; data_out=0, valid_out=0, k_out=0, sync=0. All take effect immediately, including mid-byte; partial byte discarded.
- Shift: on a CLK edge with valid_in=1, sr_n={sr[6:0],data_in}; sr<=sr_n. With valid_in=0, sr holds.
- valid_out defaults to 0 every cycle; a pulse lasts exactly one cycle.
- SEARCH: bit-by-bit test of sr_n==COM_SYMBOL.
  - On match: com_cnt<=1, bit_cnt<=0.
  - If LOCK_COUNT==1: go to LOCKED and on that same edge register data_out=COM_SYMBOL, k_out=1, valid_out=1.
  - Else go to CHECK with no output.
- CHECK: bit_cnt increments per valid bit (3-bit, wraps 7->0). At the 8th bit (bit_cnt==7):
  - sr_n==COM and com_cnt+1==LOCK_COUNT: go to LOCKED, emit the COM byte as above.
  - sr_n==COM otherwise: com_cnt++, stay in CHECK.
  - sr_n!=COM: back to SEARCH with com_cnt=0. The mismatching byte is not re-scanned; the bit search resumes from the next bit.
- LOCKED:
  - sync=1.
  - Every 8th valid bit after the locking COM: data_out<=sr_n, valid_out<=1, k_out<=(sr_n==COM_SYMBOL).
  - Latency: byte visible on the edge that samples its last bit, i.e. registered outputs 1 cycle after the last bit is presented.
  - COM patterns at non-byte-aligned positions are ignored (no realign).
- Loss of lock: valid_in=0 on any edge while in CHECK or LOCKED:
  - go to SEARCH, sync<=0, bit_cnt/com_cnt cleared, partial byte dropped, no valid_out.
  - In SEARCH, valid_in=0 just stalls.
- Holds: data_out and k_out keep the last value between strobes.
- Simultaneous: a COM completing on the same edge as reset release is not sampled; the first edge after RESET rises is the first sample.

Decomposition:
- Shared package/include pcie_defs: COM_SYMBOL default 8'hBC, state encodings SEARCH=2'd0, CHECK=2'd1, LOCKED=2'd2.
- One natural sub-module: comma_detector (shift register plus sr_n==COM compare, combinational match output). FSM, counters and output registers stay in the top.

Test Plan:
- Lock, LOCK_COUNT=1: serial 0x25,0xBC,0xF9,0x4F MSB-first with valid_in=1.
  - No strobe during 0x25, and no false match inside 0x25|0xBC.
  - Strobe data_out=BC k_out=1 sync 0->1 on the 16th bit.
  - Then F9 k=0 at bit 24, then 4F at bit 32, each exactly 8 cycles apart.
- Full stream: bytes 25,BC,F9,4F,A6,39,A8,F9,4F -> exactly 8 strobes, BC..4F in order; only BC has k_out=1.
- LOCK_COUNT=2:
  - BC,F9,BC,... -> returns to SEARCH after F9, no strobes before the locking COM.
  - BC,BC,F9 -> lock on the second BC, then F9 strobed.
- Loss of lock: locked, drop valid_in for 1 cycle mid-byte -> sync=0 next edge, no strobe, partial byte lost. Resend BC,A6 -> relock, A6 strobed.
- Async reset: assert RESET=0 between edges mid-byte while locked -> sync, valid_out, data_out, k_out go 0 without a clock edge. After release, a COM is required before any strobe.
- No-lock stream: 0x00 and 0xFF repeated -> sync stays 0, valid_out never asserts.
